// File: rtl/scan_mux_seq.sv
// scan_mux_seq
// Registered N-to-1 multiplexer of W-bit channels with two operating modes:
//   - manual: the external select picks the channel on every edge
//   - scan:   an internal pointer walks the channels, holding each one for
//             dwell+1 cycles, and pulses wrap when it comes back round
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   din      packed channels, channel i = din[i*W +: W]
//   sel      manual-mode channel select
//   mode     0 = manual, 1 = scan
//   en       block enable (0 parks the block in IDLE)
//   dwell    scan hold time minus one, sampled only when the pointer reloads
//   y        registered selected data
//   ch       index of the channel currently on y
//   valid    y/ch hold a legal selection
//   wrap     one-cycle pulse when the scan pointer returns to a lower index
//   ch_mask  (only with SCAN_MUX_MASK_EN) 1 enables a channel for scanning
//
// Optional feature macro: SCAN_MUX_MASK_EN
//   Undefined: all N channels are scanned in order 0..N-1.
//   Defined:   scan skips channels whose ch_mask bit is 0; manual ignores it.

module scan_mux_seq #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 4,
    localparam int SW     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     din,
    input  logic [SW-1:0]      sel,
    input  logic               mode,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MUX_MASK_EN
    input  logic [N-1:0]       ch_mask,
`endif
    output logic [W-1:0]       y,
    output logic [SW-1:0]      ch,
    output logic               valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SW:0]   N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0] LAST  = SW'(N-1);

    state_t               state_q, state_d;
    logic [W-1:0]         y_q, y_d;
    logic [SW-1:0]        ch_q, ch_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic [SW-1:0]        ptr_q, ptr_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    // Scan-order helpers: the channel scan starts on, the channel that follows
    // the current pointer, whether that step wraps, and whether any channel
    // is eligible at all.
    logic                 any_en;
    logic [SW-1:0]        first_idx;
    logic [SW-1:0]        next_idx;
    logic                 next_wraps;
    logic                 sel_ok;

    // Channel extraction by comparison loop so that an index >= N (possible
    // when N is not a power of two) never produces an out-of-range select.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                          input logic [SW-1:0]  idx);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i)) r = d[i*W +: W];
        end
        return r;
    endfunction

`ifdef SCAN_MUX_MASK_EN
    // Masked scan order. The search runs from the farthest candidate down to
    // the nearest so the nearest enabled channel after ptr_q wins; offset N
    // lands back on ptr_q itself when it is the only enabled channel.
    always_comb begin
        any_en     = |ch_mask;
        first_idx  = '0;
        next_idx   = ptr_q;
        next_wraps = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (ch_mask[i]) first_idx = SW'(i);
        end
        for (int k = N; k >= 1; k--) begin
            if (ch_mask[(int'(ptr_q) + k) % N]) begin
                next_idx = SW'((int'(ptr_q) + k) % N);
            end
        end
        next_wraps = (next_idx <= ptr_q);
    end
`else
    // Unmasked scan order: plain 0..N-1 with wrap on the way back to 0.
    always_comb begin
        any_en     = 1'b1;
        first_idx  = '0;
        next_idx   = (ptr_q == LAST) ? '0 : ptr_q + SW'(1);
        next_wraps = (ptr_q == LAST);
    end
`endif

    assign sel_ok = ({1'b0, sel} < N_EXT);

    // Next-state and next-output logic. Outputs are registered, so every
    // branch describes what y/ch/valid/wrap will show after this edge.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (!en) begin
            // Parked: y/ch keep their last values for a downstream display.
            state_d = IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
        end else if (!mode) begin
            state_d = MANUAL;
            ptr_d   = '0;
            cnt_d   = '0;
            ch_d    = sel;
            if (sel_ok) begin
                y_d     = pick(din, sel);
                valid_d = 1'b1;
            end else begin
                y_d     = '0;
            end
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                // Entry: present the first channel on this very edge and
                // start its dwell with the dwell value seen now.
                ptr_d = first_idx;
                cnt_d = dwell;
                if (any_en) begin
                    y_d     = pick(din, first_idx);
                    ch_d    = first_idx;
                    valid_d = 1'b1;
                end else begin
                    y_d = '0;
                end
            end else if (!any_en) begin
                y_d = '0;
            end else if (cnt_q == '0) begin
                ptr_d   = next_idx;
                cnt_d   = dwell;
                wrap_d  = next_wraps;
                y_d     = pick(din, next_idx);
                ch_d    = next_idx;
                valid_d = 1'b1;
            end else begin
                // Still dwelling: keep following live din of this channel.
                cnt_d   = cnt_q - DWELL_W'(1);
                y_d     = pick(din, ptr_q);
                ch_d    = ptr_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux_seq.sv
// tb_scan_mux_seq
// Directed bench for scan_mux_seq with N=8, W=1, DWELL_W=4. Expected values
// are written out by hand from the intended behaviour of the block.

module tb_scan_mux_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [2:0] sel;
    logic       mode;
    logic       en;
    logic [3:0] dwell;
`ifdef SCAN_MUX_MASK_EN
    logic [7:0] chMask;
`endif
    logic [0:0] y;
    logic [2:0] ch;
    logic       valid;
    logic       wrap;

    int checkCount;
    int passCount;

    scan_mux_seq #(.N(8), .W(1), .DWELL_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .sel     (sel),
        .mode    (mode),
        .en      (en),
        .dwell   (dwell),
`ifdef SCAN_MUX_MASK_EN
        .ch_mask (chMask),
`endif
        .y       (y),
        .ch      (ch),
        .valid   (valid),
        .wrap    (wrap)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before anything is
    // sampled or driven.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts it, reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Check all four outputs at once.
    task automatic checkAll(input string tag, input logic [2:0] expCh,
                            input logic expY, input logic expValid,
                            input logic expWrap);
        checkOutput({tag, ".ch"},    32'(ch),    32'(expCh));
        checkOutput({tag, ".y"},     32'(y),     32'(expY));
        checkOutput({tag, ".valid"}, 32'(valid), 32'(expValid));
        checkOutput({tag, ".wrap"},  32'(wrap),  32'(expWrap));
    endtask

    // Channel expected in each cycle of the dwell test: ch 0..2 for three
    // cycles each, ch 3 for three cycles (dwell drops to 0 after it appears),
    // then one cycle each for 4,5,6,7,0,1.
    logic [2:0] dwellChExp [18] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
                                    3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
                                    3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0;
        din   = 8'b1010_1010;
        sel   = 3'd0;
        mode  = 1'b0;
        en    = 1'b0;
        dwell = 4'd0;
`ifdef SCAN_MUX_MASK_EN
        chMask = 8'hFF;
`endif
        #1;
        checkAll("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        checkAll("idleAfterReset", 3'd0, 1'b0, 1'b0, 1'b0);

        // Manual sweep: y is bit sel of 10101010 one edge later.
        $display("[TB] manual sweep");
        en   = 1'b1;
        mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            applyStimulus();
            checkAll($sformatf("manual%0d", s), 3'(s), 1'(s % 2), 1'b1, 1'b0);
        end

        // Scan, dwell 0: one channel per cycle, wrap only on 7 -> 0.
        $display("[TB] scan dwell 0");
        mode  = 1'b1;
        dwell = 4'd0;
        applyStimulus();
        checkAll("scan0Entry", 3'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus();
            checkAll($sformatf("scan0Step%0d", k), 3'(k % 8), 1'((k % 8) % 2),
                     1'b1, 1'(k == 8));
        end

        // Scan, dwell 2, with dwell cut to 0 as ch 3 first appears.
        $display("[TB] scan dwell 2");
        mode = 1'b0;
        applyStimulus();
        mode  = 1'b1;
        dwell = 4'd2;
        for (int c = 0; c < 18; c++) begin
            applyStimulus();
            checkOutput($sformatf("dwell2Ch%0d", c), 32'(ch), 32'(dwellChExp[c]));
            checkOutput($sformatf("dwell2Wrap%0d", c), 32'(wrap), 32'(c == 16));
            if (c == 9) dwell = 4'd0;
        end

        // ch is now 1; one more edge gives ch 2, then switch to manual sel 5.
        $display("[TB] mode switch and enable drop");
        applyStimulus();
        checkOutput("preSwitchCh", 32'(ch), 32'd2);
        mode = 1'b0;
        sel  = 3'd5;
        applyStimulus();
        checkAll("toManual", 3'd5, 1'b1, 1'b1, 1'b0);
        mode = 1'b1;
        applyStimulus();
        checkAll("backToScan", 3'd0, 1'b0, 1'b1, 1'b0);
        mode = 1'b0;
        sel  = 3'd3;
        applyStimulus();
        checkAll("manual3", 3'd3, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        applyStimulus();
        checkAll("enDrop", 3'd3, 1'b1, 1'b0, 1'b0);
        din = 8'h00;
        applyStimulus();
        checkAll("idleHold", 3'd3, 1'b1, 1'b0, 1'b0);

        // Live tracking: y follows din of the channel being dwelt on.
        $display("[TB] live din");
        din   = 8'b1010_1010;
        en    = 1'b1;
        mode  = 1'b1;
        dwell = 4'd2;
        applyStimulus();
        checkAll("liveEntry", 3'd0, 1'b0, 1'b1, 1'b0);
        din = 8'b1010_1011;
        applyStimulus();
        checkAll("liveFollow", 3'd0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset between edges while ch 7 (y=1) is showing.
        $display("[TB] async reset mid-scan");
        din   = 8'b1010_1010;
        mode  = 1'b0;
        applyStimulus();
        mode  = 1'b1;
        dwell = 4'd0;
        for (int k = 0; k < 8; k++) applyStimulus();
        checkAll("preReset", 3'd7, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("asyncReset", 3'd0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        applyStimulus();
        checkAll("postReset", 3'd0, 1'b0, 1'b1, 1'b0);

`ifdef SCAN_MUX_MASK_EN
        // Mask 10010010: channels 1, 4, 7 only; wrap on 7 -> 1.
        $display("[TB] masked scan");
        mode   = 1'b0;
        applyStimulus();
        chMask = 8'b1001_0010;
        mode   = 1'b1;
        applyStimulus();
        checkAll("maskEntry", 3'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus();
        checkAll("mask4", 3'd4, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkAll("mask7", 3'd7, 1'b1, 1'b1, 1'b0);
        applyStimulus();
        checkAll("maskWrap", 3'd1, 1'b1, 1'b1, 1'b1);
        chMask = 8'h00;
        applyStimulus();
        checkOutput("maskNone.valid", 32'(valid), 32'd0);
        checkOutput("maskNone.y", 32'(y), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/scan_mux_seq.md
Name: scan_mux_seq

Overview:
- Parametrised, registered N-to-1 multiplexer of W-bit channels; the sequential successor to the fixed 8-to-1 combinational mux.
- Two modes:
  - Manual: an external select picks the channel.
  - Scan: an internal pointer walks all channels, holding on each for a programmable dwell time.
- Sits between packed multi-channel data sources and a single shared output (display/LED/serial front end).

Parameters:
- N, 8, number of input channels (2..64).
- W, 1, bits per channel.
- DWELL_W, 4, width of the dwell input.
- SW (localparam), $clog2(N), width of select and channel index.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, N*W, packed channels; channel i = din[i*W +: W].
- sel, input, SW, manual-mode channel select.
- mode, input, 1, 0 = manual, 1 = scan.
- en, input, 1, block enable.
- dwell, input, DWELL_W, scan hold time minus one, in cycles.
- y, output, W, registered selected data.
- ch, output, SW, index of the channel currently on y.
- valid, output, 1, y/ch hold a legal selection.
- wrap, output, 1, one-cycle pulse when the scan pointer returns from N-1 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous, also mid-operation):
  - y=0, ch=0, valid=0, wrap=0.
  - Internal pointer=0, dwell counter=0, state=IDLE.
- FSM states: IDLE, MANUAL, SCAN, evaluated every rising edge.
  - en=0 → IDLE.
  - en=1 & mode=0 → MANUAL.
  - en=1 & mode=1 → SCAN.
- IDLE:
  - y and ch hold their last values; valid=0, wrap=0.
  - Pointer and dwell counter cleared to 0.
- MANUAL:
  - At each edge: y <= channel sel, ch <= sel, valid <= 1.
  - Latency is exactly one cycle from sel/din to y.
  - If sel >= N (non-power-of-2 N): y <= 0, ch <= sel, valid <= 0.
- SCAN:
  - Entry from IDLE or MANUAL: pointer=0; dwell counter loaded with dwell.
  - First SCAN edge presents channel 0.
  - Each edge: y <= channel[pointer], ch <= pointer, valid <= 1. y tracks live din of the current channel; it is not a snapshot.
  - Dwell counter decrements each edge.
  - When the counter is 0: pointer advances (N-1 → 0 wraps), and the counter reloads from the current dwell value. dwell is sampled only at reload.
  - Each channel is presented for exactly dwell+1 cycles; dwell=0 gives one channel per cycle.
  - wrap=1 for exactly the one cycle in which ch first shows 0 after N-1; it is 0 at scan entry.
- Mode change mid-scan: MANUAL behaviour starts on the next edge. A later return to SCAN restarts at channel 0.
- en and mode changes are synchronous; no glitch on y between edges.

Optional Feature:
- Macro: SCAN_MUX_MASK_EN.
- Defined:
  - Adds input port ch_mask [N-1:0]. A 1 enables a channel for scan.
  - The scan pointer advances to the next enabled index (modulo N) and skips masked channels in the same cycle.
  - wrap pulses when the pointer moves to an index lower than or equal to its current index.
  - Scan entry lands on the lowest enabled channel.
  - If ch_mask is all zero: y <= 0, valid <= 0, pointer holds.
  - Manual mode ignores the mask.
- Undefined: no ch_mask port; all N channels are scanned in order 0..N-1.

Test Plan:
- Reset: rst_n=0 asserted mid-scan at any time → y=0, ch=0, valid=0, wrap=0 immediately, without waiting for a clk edge.
- Manual sweep: N=8, W=1, din=8'b10101010, en=1, mode=0, sel=0..7, one per cycle → one cycle later y=0,1,0,1,0,1,0,1 and ch=sel, valid=1.
- Scan dwell=0: same din, mode=1 → ch=0,1,..,7,0 on consecutive cycles, y alternating 0,1; wrap=1 only on the cycle ch returns to 0.
- Scan dwell=2 with mid-scan change: dwell=2 → each ch held 3 cycles. Change dwell to 0 while ch=3 → ch=3 still lasts 3 cycles, then ch 4 onward lasts 1 cycle each.
- Mode switch and en drop:
  - Mode 1→0 with sel=5 while ch=2 → next edge ch=5.
  - Back to mode=1 → ch=0 next edge.
  - en=0 → valid=0, y holds its value.
- Mask (SCAN_MUX_MASK_EN): ch_mask=8'b10010010, dwell=0 → ch=1,4,7,1, wrap on the 7→1 transition. ch_mask=0 → valid=0.
